hicore_flush_fifo: RTL and testbench

Parametrised synchronous valid/ready FIFO with a per-entry cancel tag, for inter-stage buffering in the HiCore pipeline (IF→ID instruction queue, LSU response queue).
On a branch/flush, every entry held or entering that cycle is marked cancelled rather than dropped. Downstream stages discard cancelled entries under the existing cancel protocol.
It supersedes the single-entry pipe register and the fixed-depth sync FIFO with correct wrap, occupancy reporting, optional same-cycle push-when-full and optional zero-latency bypass.

---
 rtl/hicore_fifo_pkg.sv | 18 +
 rtl/hicore_flush_fifo_if.sv | 34 +++
 rtl/hicore_fifo_mem.sv | 42 ++++
 rtl/hicore_flush_fifo.sv | 96 +++++++++
 tb/tb_hicore_flush_fifo.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/hicore_fifo_pkg.sv
// Shared definitions for the HiCore FIFO family: pointer sizing, tag width and
// a width-agnostic wrap-around pointer increment.
package hicore_fifo_pkg;

  localparam int unsigned TAG_W = 1;

  function automatic int unsigned ptr_w(input int unsigned dp);
    return unsigned'($clog2(dp)) + 1;
  endfunction

  // The caller truncates the result to its own pointer width.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (ptr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/hicore_flush_fifo_if.sv
// Valid/ready bus of hicore_flush_fifo: upstream push side, downstream pop side,
// flush and occupancy status. master = surrounding pipeline, slave = FIFO.
interface hicore_flush_fifo_if #(
  parameter int DW = 32,
  parameter int DP = 4
);
  import hicore_fifo_pkg::*;

  localparam int unsigned CW = ptr_w(DP);

  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          i_cancel;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic          o_cancel;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output i_vld, i_dat, i_cancel, o_rdy, flush,
    input  i_rdy, o_vld, o_dat, o_cancel, count, full, empty
  );

  modport slave (
    input  i_vld, i_dat, i_cancel, o_rdy, flush,
    output i_rdy, o_vld, o_dat, o_cancel, count, full, empty
  );

endinterface

// File: rtl/hicore_fifo_mem.sv
// DP x (DW+1) storage for hicore_flush_fifo: one write port, combinational read,
// and a bulk set of every cancel tag on flush. Payload bits are not reset.
module hicore_fifo_mem
  import hicore_fifo_pkg::*;
#(
  parameter int DW = 32,
  parameter int DP = 4,
  parameter int AW = $clog2(DP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [DW+TAG_W-1:0] wdata,
  input  logic                flush,
  input  logic [AW-1:0]       raddr,
  output logic [DW+TAG_W-1:0] rdata
);

  logic [DW-1:0] dat_q [DP];
  logic [DP-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (wen) begin
      dat_q[waddr] <= wdata[DW-1:0];
    end
  end

  // Flush tags every slot; a slot freed this cycle is rewritten before reuse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else if (flush) begin
      tag_q <= '1;
    end else if (wen) begin
      tag_q[waddr] <= wdata[DW+TAG_W-1];
    end
  end

  assign rdata = {tag_q[raddr], dat_q[raddr]};

endmodule

// File: rtl/hicore_flush_fifo.sv
// Synchronous valid/ready FIFO with per-entry cancel tag and flush marking.
// Optional zero-latency bypass when empty: define HICORE_FIFO_BYPASS_EN.
module hicore_flush_fifo
  import hicore_fifo_pkg::*;
#(
  parameter int DW        = 32,
  parameter int DP        = 4,
  parameter bit CUT_READY = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  hicore_flush_fifo_if.slave           bus
);

  localparam int unsigned PTR_W = ptr_w(DP);
  localparam int unsigned AW    = PTR_W - 1;

  if ((DP < 2) || ((DP & (DP - 1)) != 0)) begin : g_dp_check
    $error("hicore_flush_fifo: DP must be a power of two and at least 2");
  end

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                empty_s, full_s;
  logic                push_s, pop_s;
  logic                wen_s, ren_s;
  logic                byp_s;
  logic [DW+TAG_W-1:0] wdata_s, rdata_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Non-cut ready lets a full FIFO accept while the head leaves this cycle.
  assign bus.i_rdy = CUT_READY ? ~full_s : (~full_s | bus.o_rdy);

`ifdef HICORE_FIFO_BYPASS_EN
  assign byp_s = empty_s & bus.i_vld;
`else
  assign byp_s = 1'b0;
`endif

  assign bus.o_vld    = ~empty_s | byp_s;
  assign bus.o_dat    = byp_s ? bus.i_dat : rdata_s[DW-1:0];
  assign bus.o_cancel = byp_s ? (bus.i_cancel | bus.flush)
                              : (~empty_s & rdata_s[DW+TAG_W-1]);

  assign push_s = bus.i_vld & bus.i_rdy;
  assign pop_s  = bus.o_vld & bus.o_rdy;

  // A bypassed entry taken downstream in the same cycle never touches storage.
  assign wen_s   = push_s & ~(byp_s & bus.o_rdy);
  assign ren_s   = pop_s & ~empty_s;
  assign wdata_s = {bus.i_cancel | bus.flush, bus.i_dat};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wen_s) begin
      wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), PTR_W));
    end
    if (ren_s) begin
      rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), PTR_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign bus.count = wr_ptr_q - rd_ptr_q;
  assign bus.full  = full_s;
  assign bus.empty = empty_s;

  hicore_fifo_mem #(
    .DW (DW),
    .DP (DP),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (wen_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata_s),
    .flush (bus.flush),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata_s)
  );

endmodule

// File: tb/tb_hicore_flush_fifo.sv
// Bench for hicore_flush_fifo: two instances (CUT_READY=0 and 1) share stimulus
// and are each checked against a queue model of FIFO order, tags and handshakes.
module tb_hicore_flush_fifo;

  localparam int DW = 8;
  localparam int DP = 4;
`ifdef HICORE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          vld   = 1'b0;
  logic [DW-1:0] dat   = '0;
  logic          cnc   = 1'b0;
  logic          ordy  = 1'b0;
  logic          fl    = 1'b0;

  int ncmp = 0;
  int nmis = 0;

  logic [DW:0] mq [2][$];

  always #5 clk = ~clk;

  hicore_flush_fifo_if #(.DW(DW), .DP(DP)) if0 ();
  hicore_flush_fifo_if #(.DW(DW), .DP(DP)) if1 ();

  assign if0.i_vld = vld;  assign if0.i_dat = dat;  assign if0.i_cancel = cnc;
  assign if0.o_rdy = ordy; assign if0.flush = fl;
  assign if1.i_vld = vld;  assign if1.i_dat = dat;  assign if1.i_cancel = cnc;
  assign if1.o_rdy = ordy; assign if1.flush = fl;

  hicore_flush_fifo #(.DW(DW), .DP(DP), .CUT_READY(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  hicore_flush_fifo #(.DW(DW), .DP(DP), .CUT_READY(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic sample(input int k, output logic [31:0] cnt, output logic fu, output logic em,
                        output logic ir, output logic ov, output logic [DW-1:0] od,
                        output logic oc);
    if (k == 0) begin
      cnt = 32'(if0.count); fu = if0.full; em = if0.empty; ir = if0.i_rdy;
      ov = if0.o_vld; od = if0.o_dat; oc = if0.o_cancel;
    end else begin
      cnt = 32'(if1.count); fu = if1.full; em = if1.empty; ir = if1.i_rdy;
      ov = if1.o_vld; od = if1.o_dat; oc = if1.o_cancel;
    end
  endtask

  task automatic reset_check(input string tag);
    logic [31:0] cnt; logic fu, em, ir, ov, oc; logic [DW-1:0] od;
    for (int k = 0; k < 2; k++) begin
      sample(k, cnt, fu, em, ir, ov, od, oc);
      check($sformatf("%s u%0d count", tag, k), cnt, 0);
      check($sformatf("%s u%0d empty", tag, k), 32'(em), 1);
      check($sformatf("%s u%0d full", tag, k), 32'(fu), 0);
      check($sformatf("%s u%0d i_rdy", tag, k), 32'(ir), 1);
      check($sformatf("%s u%0d o_vld", tag, k), 32'(ov), 0);
      check($sformatf("%s u%0d o_cancel", tag, k), 32'(oc), 0);
    end
  endtask

  // Compare one instance against its queue, then advance the queue by one clock.
  task automatic model_cycle(input int k);
    logic [31:0] cnt; logic fu, em, ir, ov, oc; logic [DW-1:0] od;
    int      n;
    bit      e_emp, e_full, e_ir, e_byp, e_ov, e_oc, push, pop;
    logic [DW-1:0] e_od;
    sample(k, cnt, fu, em, ir, ov, od, oc);
    n      = mq[k].size();
    e_emp  = (n == 0);
    e_full = (n == DP);
    e_ir   = (k == 1) ? !e_full : (!e_full || ordy);
    e_byp  = BYP && e_emp && vld;
    e_ov   = !e_emp || e_byp;
    e_od   = '0;
    e_oc   = 1'b0;
    if (e_byp) begin
      e_od = dat; e_oc = cnc | fl;
    end else if (!e_emp) begin
      e_od = mq[k][0][DW-1:0]; e_oc = mq[k][0][DW];
    end
    check($sformatf("u%0d count", k), cnt, 32'(n));
    check($sformatf("u%0d full", k), 32'(fu), 32'(e_full));
    check($sformatf("u%0d empty", k), 32'(em), 32'(e_emp));
    check($sformatf("u%0d i_rdy", k), 32'(ir), 32'(e_ir));
    check($sformatf("u%0d o_vld", k), 32'(ov), 32'(e_ov));
    check($sformatf("u%0d o_cancel", k), 32'(oc), 32'(e_oc));
    if (e_ov) check($sformatf("u%0d o_dat", k), 32'(od), 32'(e_od));

    push = vld && e_ir;
    pop  = e_ov && ordy;
    if (pop && !e_byp) void'(mq[k].pop_front());
    if (fl) for (int i = 0; i < mq[k].size(); i++) mq[k][i][DW] = 1'b1;
    if (push && !(e_byp && ordy)) mq[k].push_back({cnc | fl, dat});
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic c,
                      input logic r, input logic f);
    vld = v; dat = d; cnc = c; ordy = r; fl = f;
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_cycle(k);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 reset_check("rst");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with o_rdy low, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Push/pop pairs at low occupancy so pointers wrap.
    step(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 8'hB1 + 8'(i), 1'(i % 3 == 0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Flush with a push and a pop in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with three entries resident.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
    vld = 1'b0; ordy = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_check("async_rst");
    mq[0].delete(); mq[1].delete();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Empty with o_rdy high, then low (zero-latency path when bypass is built in).
    step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
